dsp_mem_loader: RTL
===================

// Module: dsp_mem_loader
// PURPOSE
//  Stream-fed loader for per-core DSP program/envelope/frequency memories; generalises fixed 3-core x 3-mem write decode.
//  Accepts framed bursts on a valid/ready word stream, decodes core/mem target, auto-increments address, drives shared write bus.
//  Sits between host/bench stimulus and the per-core aligned_ram instances feeding the dsp block.
// PARAMETERS
//  N_CORES    3   number of processor cores served
//  N_MEM      3   memories per core (0 cmd, 1 env, 2 freq, ...)
//  DATAWIDTH  32  stream and memory write data width
//  ADDRWIDTH  16  memory write address width (per-mem slices taken downstream)
//  LENWIDTH   16  burst length field width, words
// PORTS
//  clk             in   1                clock
//  reset           in   1                synchronous, active-high reset
//  s_data          in   DATAWIDTH        stream word
//  s_valid         in   1                stream word valid
//  s_ready         out  1                loader accepts word (beat = s_valid & s_ready)
//  abort           in   1                abandon current burst
//  err_clr         in   1                clear sticky err
//  mem_write_data  out  DATAWIDTH        shared write data
//  mem_write_addr  out  ADDRWIDTH        shared write address
//  mem_write_en    out  N_CORES*N_MEM    one-hot enable, bit core*N_MEM+mem
//  busy            out  1                burst in progress (state != IDLE)
//  done            out  1                1-cycle pulse, burst completed
//  err             out  1                sticky error flag
//  checksum        out  DATAWIDTH        burst data sum (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; s_ready=1; mem_write_en=0; mem_write_data/addr=0; busy=0; done=0; err=0; checksum=0.
//  Frame: H0 {[31:24] core, [23:16] mem, [LENWIDTH-1:0] len}; H1 {[ADDRWIDTH-1:0] start addr}; then len data words.
//  States: IDLE -beat-> ADDR -beat-> DATA -last beat-> DONE -> IDLE; IDLE -bad H0-> FLUSH (len>0) or IDLE (len=0).
//  H0 invalid if core>=N_CORES or mem>=N_MEM or len==0: err<=1, no writes; FLUSH consumes len beats after H1, discards.
//  DATA beat at cycle n -> cycle n+1: mem_write_en one-hot, data=beat word, addr=start+k (k = beat index from 0). Latency 1.
//  No beat (s_valid=0) -> mem_write_en=0 next cycle; counters hold. Gaps anywhere in frame allowed.
//  Last data beat at n: cycle n+1 last write + done=1, state DONE, s_ready=0; cycle n+2 IDLE, s_ready=1.
//  s_ready=1 in IDLE/ADDR/DATA/FLUSH, 0 only in DONE.
//  Address wrap: start+k computed mod 2^ADDRWIDTH; write still performed; crossing 2^ADDRWIDTH-1 -> 0 sets err.
//  abort: highest priority after reset; any state -> IDLE next cycle, no done, err<=1 if state != IDLE; beat in abort cycle dropped.
//  err_clr clears err; simultaneous new error and err_clr -> err=1 (set wins).
//  busy=1 whenever state != IDLE, including DONE and FLUSH.
//  Reset mid-burst: all outputs to reset values next edge, partial burst abandoned, no done.
// CONFIGURATION
//  DSP_MEM_LOADER_CHECKSUM_EN defined: checksum = sum mod 2^DATAWIDTH of burst data words, cleared at H0,
//   updated on each DATA beat, final value valid with done and held until next H0.
//  Undefined: adder absent, checksum tied to 0; all other behaviour identical.
// STRUCTURE
//  dsp_mem_loader_pkg: state enum (IDLE, ADDR, DATA, DONE, FLUSH), H0 field lsb/msb constants, MEM_CMD=0/MEM_ENV=1/MEM_FREQ=2.
//  Sub-module dsp_mem_loader_wen_decode: (core, mem, en) -> registered one-hot mem_write_en; no other hierarchy.
// TESTING
//  H0 core=1,mem=0,len=4; H1 addr=0x10; data 1,2,3,4 back-to-back -> en bit 3 for 4 cycles, addr 0x10..0x13, done on last, err=0.
//  Same frame with s_valid low every other cycle -> identical writes spread over gaps, done once after 4th write.
//  H0 core=3 (N_CORES=3), len=2; H1; 2 words; then valid frame -> err=1, zero writes for bad frame, valid frame writes correctly.
//  H0 core=2,mem=2,len=3; H1 addr=0xFFFE -> addrs 0xFFFE,0xFFFF,0x0000 on en bit 8; err=1 after wrap.
//  abort after 2 of 5 data words -> 2 writes only, no done, err=1; err_clr -> err=0; next frame completes normally.
//  With macro: data 0xFFFFFFFF,0x2 -> checksum=0x00000001 at done; without macro checksum stays 0.

Source files
------------

// File: rtl/dsp_mem_loader_pkg.sv
// Shared types and constants for the DSP memory loader.
// H0 field positions, loader states and memory indices.
package dsp_mem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    DONE,
    FLUSH
  } state_e;

  localparam int H0_CORE_MSB = 31;
  localparam int H0_CORE_LSB = 24;
  localparam int H0_MEM_MSB  = 23;
  localparam int H0_MEM_LSB  = 16;

  localparam int MEM_CMD  = 0;
  localparam int MEM_ENV  = 1;
  localparam int MEM_FREQ = 2;

endpackage

// File: rtl/dsp_mem_loader_wen_decode.sv
// Registered one-hot write-enable decode.
// Bit core*N_MEM+mem is raised one cycle after en.
module dsp_mem_loader_wen_decode #(
  parameter int N_CORES = 3,
  parameter int N_MEM   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               core,
  input  logic [7:0]               mem,
  input  logic                     en,
  output logic [N_CORES*N_MEM-1:0] wen
);
  import dsp_mem_loader_pkg::*;

  logic [N_CORES*N_MEM-1:0] wen_d, wen_q;

  // one-hot select of the target memory
  always_comb begin
    wen_d = '0;
    for (int i = 0; i < N_CORES*N_MEM; i++) begin
      if (en && (int'(core) * N_MEM + int'(mem) == i)) begin
        wen_d[i] = 1'b1;
      end
    end
  end

  // enable register
  always_ff @(posedge clk) begin
    if (reset) wen_q <= '0;
    else       wen_q <= wen_d;
  end

  assign wen = wen_q;

endmodule

// File: rtl/dsp_mem_loader.sv
// Framed stream loader for per-core DSP memories.
// Optional burst checksum: DSP_MEM_LOADER_CHECKSUM_EN.
module dsp_mem_loader #(
  parameter int N_CORES   = 3,
  parameter int N_MEM     = 3,
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 16,
  parameter int LENWIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATAWIDTH-1:0]     s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     abort,
  input  logic                     err_clr,
  output logic [DATAWIDTH-1:0]     mem_write_data,
  output logic [ADDRWIDTH-1:0]     mem_write_addr,
  output logic [N_CORES*N_MEM-1:0] mem_write_en,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [DATAWIDTH-1:0]     checksum
);
  import dsp_mem_loader_pkg::*;

  localparam logic [LENWIDTH:0]    CNT_ONE  = 1;
  localparam logic [ADDRWIDTH-1:0] ADDR_ONE = 1;

  state_e                 state_q, state_d;
  logic [7:0]             core_q, core_d;
  logic [7:0]             mem_q, mem_d;
  logic [LENWIDTH:0]      cnt_q, cnt_d;
  logic [ADDRWIDTH-1:0]   addr_q, addr_d;
  logic [ADDRWIDTH-1:0]   waddr_q, waddr_d;
  logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   err_set, wen_en, beat;
  logic [7:0]             h0_core, h0_mem;
  logic [LENWIDTH-1:0]    h0_len;
  logic                   h0_bad;

  assign s_ready = (state_q != DONE);
  assign beat    = s_valid & s_ready;
  assign h0_core = s_data[H0_CORE_MSB:H0_CORE_LSB];
  assign h0_mem  = s_data[H0_MEM_MSB:H0_MEM_LSB];
  assign h0_len  = s_data[LENWIDTH-1:0];
  assign h0_bad  = (int'(h0_core) >= N_CORES) |
                   (int'(h0_mem) >= N_MEM) |
                   (h0_len == '0);

  // frame sequencing, address generation and error detection
  always_comb begin
    state_d = state_q;
    core_d  = core_q;
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_set = 1'b0;
    wen_en  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      err_set = (state_q != IDLE);
    end else begin
      unique case (state_q)
        IDLE: if (beat) begin
          core_d = h0_core;
          mem_d  = h0_mem;
          cnt_d  = {1'b0, h0_len};
          if (h0_bad) begin
            err_set = 1'b1;
            cnt_d   = {1'b0, h0_len} + CNT_ONE;
            state_d = (h0_len == '0) ? IDLE : FLUSH;
          end else begin
            state_d = ADDR;
          end
        end
        ADDR: if (beat) begin
          addr_d  = s_data[ADDRWIDTH-1:0];
          state_d = DATA;
        end
        DATA: if (beat) begin
          wen_en  = 1'b1;
          wdata_d = s_data;
          waddr_d = addr_q;
          addr_d  = addr_q + ADDR_ONE;
          cnt_d   = cnt_q - CNT_ONE;
          if (addr_q == '1 && cnt_q != CNT_ONE) err_set = 1'b1;
          if (cnt_q == CNT_ONE) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        DONE: state_d = IDLE;
        FLUSH: if (beat) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    err_d = err_set | (err_q & ~err_clr);
  end

  // loader state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      core_q  <= '0;
      mem_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      core_q  <= core_d;
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  dsp_mem_loader_wen_decode #(
    .N_CORES (N_CORES),
    .N_MEM   (N_MEM)
  ) u_wen (
    .clk   (clk),
    .reset (reset),
    .core  (core_q),
    .mem   (mem_q),
    .en    (wen_en),
    .wen   (mem_write_en)
  );

`ifdef DSP_MEM_LOADER_CHECKSUM_EN
  logic [DATAWIDTH-1:0] cksum_q, cksum_d;

  // running sum of burst data, restarted by each H0
  always_comb begin
    cksum_d = cksum_q;
    if (!abort && beat) begin
      if (state_q == IDLE)      cksum_d = '0;
      else if (state_q == DATA) cksum_d = cksum_q + s_data;
    end
  end

  // checksum register
  always_ff @(posedge clk) begin
    if (reset) cksum_q <= '0;
    else       cksum_q <= cksum_d;
  end

  assign checksum = cksum_q;
`else
  assign checksum = '0;
`endif

  assign mem_write_data = wdata_q;
  assign mem_write_addr = waddr_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign err            = err_q;

endmodule
